// File: rtl/controlador_es_if.sv
// Core-side bundle for controlador_es: IN handshake, OUT write strobe,
// display selection and the converted display outputs.
interface controlador_es_if #(
  parameter int DATA_W  = 32,
  parameter int IN_W    = 18,
  parameter int NUM_DIG = 8,
  parameter int OUT_CH  = 2
);
  localparam int CH_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  logic [IN_W-1:0]      entrada;
  logic                 enter;
  logic                 in_req;
  logic                 in_ack;
  logic [DATA_W-1:0]    in_dado;
  logic                 stall;
  logic                 out_req;
  logic [CH_W-1:0]      out_ch;
  logic [DATA_W-1:0]    out_dado;
  logic [CH_W-1:0]      disp_sel;
  logic                 out_busy;
  logic [4*NUM_DIG-1:0] digitos;
  logic                 neg;
  logic                 ovf;

  modport slave (
    input  entrada, enter, in_req, out_req, out_ch, out_dado, disp_sel,
    output in_ack, in_dado, stall, out_busy, digitos, neg, ovf
  );

  modport master (
    output entrada, enter, in_req, out_req, out_ch, out_dado, disp_sel,
    input  in_ack, in_dado, stall, out_busy, digitos, neg, ovf
  );
endinterface

// File: rtl/controlador_es.sv
// I/O controller: debounced enter key for IN, latched OUT channels and a
// sequential signed binary-to-BCD converter for the displayed channel.
module controlador_es #(
  parameter int DATA_W  = 32,
  parameter int IN_W    = 18,
  parameter int DEB_CYC = 4,
  parameter int NUM_DIG = 8,
  parameter int OUT_CH  = 2
) (
  input logic          clock,
  input logic          reset,
  controlador_es_if.slave bus
);
  localparam int CH_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam int SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  // Decimal digits of 2^DATA_W-1 is floor(DATA_W*log10(2))+1.
  localparam int BCD_D = (DATA_W * 30103) / 100000 + 1;
  localparam int TOT_D = (BCD_D > NUM_DIG) ? BCD_D : NUM_DIG;
  localparam int BCD_W = 4 * TOT_D;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(DATA_W - 1);
  localparam logic [CH_W:0]    NCH      = (CH_W + 1)'(OUT_CH);

  // ---------------- enter synchroniser and debouncer ----------------
  logic             sync1, sync2, deb_lvl;
  logic [CNT_W-1:0] deb_cnt;
  logic             flip, press;

  // press fires on the edge where the debounced level becomes 1
  assign flip  = (sync2 != deb_lvl) && (deb_cnt == DEB_LAST);
  assign press = flip && sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= bus.enter;
      sync2 <= sync1;
      if (sync2 != deb_lvl) begin
        if (flip) begin
          deb_lvl <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // ---------------- IN handshake FSM ----------------
  typedef enum logic {IN_IDLE, IN_WAIT} in_state_t;

  in_state_t         in_st;
  logic              ack_q;
  logic [DATA_W-1:0] dado_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_st  <= IN_IDLE;
      ack_q  <= 1'b0;
      dado_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (in_st)
        IN_IDLE: begin
          if (bus.in_req) in_st <= IN_WAIT;
        end
        IN_WAIT: begin
          if (!bus.in_req) begin
            in_st <= IN_IDLE;
          end else if (press) begin
            dado_q <= DATA_W'($signed(bus.entrada));
            ack_q  <= 1'b1;
            in_st  <= IN_IDLE;
          end
        end
        default: in_st <= IN_IDLE;
      endcase
    end
  end

  assign bus.in_ack  = ack_q;
  assign bus.in_dado = dado_q;
  assign bus.stall   = bus.in_req & ~ack_q;

  // ---------------- output channels ----------------
  logic [DATA_W-1:0] chan [OUT_CH];
  logic              wr_ok, sel_ok, trigger;
  logic [CH_W-1:0]   sel_q;
  logic [DATA_W-1:0] src_val, mag;

  assign wr_ok   = bus.out_req && ({1'b0, bus.out_ch} < NCH);
  assign sel_ok  = {1'b0, bus.disp_sel} < NCH;
  assign trigger = (wr_ok && (bus.out_ch == bus.disp_sel)) || (bus.disp_sel != sel_q);
  assign src_val = sel_ok ? chan[bus.disp_sel] : '0;
  // Two's-complement negate on DATA_W bits keeps -2^(DATA_W-1) representable.
  assign mag     = src_val[DATA_W-1] ? (~src_val + DATA_W'(1)) : src_val;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < OUT_CH; i++) chan[i] <= '0;
    end else if (wr_ok) begin
      chan[bus.out_ch] <= bus.out_dado;
    end
  end

  // ---------------- double-dabble converter ----------------
  typedef enum logic [1:0] {CV_IDLE, CV_LOAD, CV_SHIFT} cv_state_t;

  cv_state_t            cv_st;
  logic                 busy_q, pend_q, sign_q;
  logic [DATA_W-1:0]    bin_q, bin_nx;
  logic [BCD_W-1:0]     bcd_q, bcd_adj, bcd_nx;
  logic [SH_W-1:0]      sh_cnt;
  logic [4*NUM_DIG-1:0] dig_q, res_dig;
  logic                 neg_q, ovf_q, hi_nz;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned d = 0; d < TOT_D; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    {bcd_nx, bin_nx} = {bcd_adj, bin_q} << 1;
    hi_nz = 1'b0;
    for (int unsigned d = NUM_DIG; d < TOT_D; d++) begin
      if (bcd_nx[4*d +: 4] != 4'd0) hi_nz = 1'b1;
    end
    res_dig = hi_nz ? '1 : bcd_nx[4*NUM_DIG-1:0];
  end

  // Triggers while busy collapse into pend_q; the finishing edge restarts
  // straight into a fresh load so out_busy never drops between runs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cv_st  <= CV_IDLE;
      busy_q <= 1'b0;
      pend_q <= 1'b0;
      sign_q <= 1'b0;
      bin_q  <= '0;
      bcd_q  <= '0;
      sh_cnt <= '0;
      dig_q  <= '0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      sel_q  <= '0;
    end else begin
      sel_q <= bus.disp_sel;
      case (cv_st)
        CV_IDLE: begin
          if (trigger) begin
            cv_st  <= CV_LOAD;
            busy_q <= 1'b1;
          end
        end
        CV_LOAD: begin
          sign_q <= src_val[DATA_W-1];
          bin_q  <= mag;
          bcd_q  <= '0;
          sh_cnt <= '0;
          cv_st  <= CV_SHIFT;
          if (trigger) pend_q <= 1'b1;
        end
        CV_SHIFT: begin
          bin_q  <= bin_nx;
          bcd_q  <= bcd_nx;
          sh_cnt <= sh_cnt + SH_W'(1);
          if (sh_cnt == SH_LAST) begin
            dig_q  <= res_dig;
            neg_q  <= sign_q;
            ovf_q  <= hi_nz;
            pend_q <= 1'b0;
            if (pend_q || trigger) begin
              cv_st <= CV_LOAD;
            end else begin
              cv_st  <= CV_IDLE;
              busy_q <= 1'b0;
            end
          end else if (trigger) begin
            pend_q <= 1'b1;
          end
        end
        default: begin
          cv_st  <= CV_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_busy = busy_q;
  assign bus.digitos  = dig_q;
  assign bus.neg      = neg_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_controlador_es.sv
// Directed bench for controlador_es with a cycle-level reference model and
// literal checkpoints on the key scenarios.
module tb_controlador_es;
  localparam int DATA_W  = 32;
  localparam int IN_W    = 18;
  localparam int DEB_CYC = 4;
  localparam int NUM_DIG = 8;
  localparam int OUT_CH  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  controlador_es_if #(.DATA_W(DATA_W), .IN_W(IN_W), .NUM_DIG(NUM_DIG), .OUT_CH(OUT_CH)) bus ();

  controlador_es #(
    .DATA_W(DATA_W), .IN_W(IN_W), .DEB_CYC(DEB_CYC), .NUM_DIG(NUM_DIG), .OUT_CH(OUT_CH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_h [0:DEB_CYC+1];
  bit          m_lvl = 1'b0, m_wait = 1'b0, m_ack = 1'b0, m_pend = 1'b0;
  logic [31:0] m_dado = '0, m_val = '0;
  logic [31:0] m_reg [OUT_CH];
  int          m_sel_prev = 0;
  int          m_left = 0;
  logic [31:0] m_dig = '0;
  bit          m_neg = 1'b0, m_ovf = 1'b0;

  always @(posedge clock) begin : model
    bit     fl, press, wr, tr;
    longint mag;
    if (reset) begin
      for (int j = 0; j <= DEB_CYC + 1; j++) m_h[j] = 1'b0;
      m_lvl = 0; m_wait = 0; m_ack = 0; m_pend = 0; m_dado = '0;
      for (int c = 0; c < OUT_CH; c++) m_reg[c] = '0;
      m_sel_prev = 0; m_left = 0; m_dig = '0; m_neg = 0; m_ovf = 0;
    end else begin
      // Debounced level flips once the last DEB_CYC synchronised samples all disagree.
      fl = 1'b1;
      for (int j = 1; j <= DEB_CYC; j++) if (m_h[j] == m_lvl) fl = 1'b0;
      press = fl && !m_lvl;
      if (fl) m_lvl = !m_lvl;
      for (int j = DEB_CYC + 1; j > 0; j--) m_h[j] = m_h[j-1];
      m_h[0] = bus.enter;

      m_ack = 1'b0;
      if (m_wait) begin
        if (!bus.in_req) m_wait = 1'b0;
        else if (press) begin
          m_ack  = 1'b1;
          m_dado = {{(DATA_W-IN_W){bus.entrada[IN_W-1]}}, bus.entrada};
          m_wait = 1'b0;
        end
      end else if (bus.in_req) m_wait = 1'b1;

      wr = bus.out_req && (int'(bus.out_ch) < OUT_CH);
      tr = (wr && bus.out_ch == bus.disp_sel) || (int'(bus.disp_sel) != m_sel_prev);
      m_sel_prev = int'(bus.disp_sel);
      if (m_left == 0) begin
        if (tr) m_left = DATA_W + 1;
      end else begin
        if (m_left == DATA_W + 1) m_val = m_reg[bus.disp_sel];
        m_left--;
        if (m_left == 0) begin
          m_neg = m_val[31];
          mag = m_val[31] ? (longint'(1) <<< 32) - longint'({32'd0, m_val}) : longint'({32'd0, m_val});
          if (mag > 64'd99999999) begin
            m_ovf = 1'b1;
            m_dig = '1;
          end else begin
            m_ovf = 1'b0;
            for (int d = 0; d < NUM_DIG; d++) begin
              m_dig[4*d +: 4] = 4'(mag % 10);
              mag = mag / 10;
            end
          end
          if (m_pend || tr) begin
            m_left = DATA_W + 1;
            m_pend = 1'b0;
          end
        end else if (tr) m_pend = 1'b1;
      end
      if (wr) m_reg[bus.out_ch] = bus.out_dado;
    end
  end

  always @(negedge clock) begin : compare
    chk("in_ack",   64'(bus.in_ack),   64'(m_ack));
    chk("in_dado",  64'(bus.in_dado),  64'(m_dado));
    chk("stall",    64'(bus.stall),    64'(bus.in_req & ~m_ack));
    chk("out_busy", 64'(bus.out_busy), 64'(m_left != 0));
    chk("digitos",  64'(bus.digitos),  64'(m_dig));
    chk("neg",      64'(bus.neg),      64'(m_neg));
    chk("ovf",      64'(bus.ovf),      64'(m_ovf));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.out_busy && n < 200) begin
      n++;
      step(1);
    end
  endtask

  task automatic write_ch(input logic ch, input logic [31:0] v);
    bus.out_req  = 1'b1;
    bus.out_ch   = ch;
    bus.out_dado = v;
    step(1);
    bus.out_req  = 1'b0;
  endtask

  task automatic press_and_expect(input logic [31:0] dado, input string nm);
    int acks;
    acks = 0;
    bus.enter = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (bus.in_ack) begin
        acks++;
        chk({nm, "_latency"}, 64'(c), 64'(2 + DEB_CYC));
        chk({nm, "_dado"}, 64'(bus.in_dado), 64'(dado));
        bus.in_req = 1'b0;
      end else if (acks == 0) begin
        chk({nm, "_stall"}, 64'(bus.stall), 64'(1));
      end
    end
    chk({nm, "_acks"}, 64'(acks), 64'(1));
    bus.enter = 1'b0;
    step(8);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n, acks;
    bus.entrada  = '0;
    bus.enter    = 1'b0;
    bus.in_req   = 1'b0;
    bus.out_req  = 1'b0;
    bus.out_ch   = '0;
    bus.out_dado = '0;
    bus.disp_sel = '0;
    step(3);
    reset = 1'b0;
    chk("rst_busy",    64'(bus.out_busy), 64'(0));
    chk("rst_digitos", 64'(bus.digitos),  64'(0));
    chk("rst_ack",     64'(bus.in_ack),   64'(0));

    // 1234 on channel 0
    write_ch(1'b0, 32'd1234);
    wait_idle(n);
    chk("busy_1234", 64'(n), 64'(33));
    chk("dig_1234", 64'(bus.digitos), 64'(32'h00001234));
    chk("model_1234", 64'(m_dig), 64'(32'h00001234));
    chk("neg_1234", 64'(bus.neg), 64'(0));

    // -5 into ch1 while switching disp_sel: a single trigger
    bus.disp_sel = 1'b1;
    write_ch(1'b1, 32'hFFFF_FFFB);
    wait_idle(n);
    chk("busy_m5", 64'(n), 64'(33));
    chk("dig_m5", 64'(bus.digitos), 64'(32'h00000005));
    chk("neg_m5", 64'(bus.neg), 64'(1));

    // most negative value overflows the display
    write_ch(1'b1, 32'h8000_0000);
    wait_idle(n);
    chk("dig_min", 64'(bus.digitos), 64'(32'hFFFF_FFFF));
    chk("ovf_min", 64'(bus.ovf), 64'(1));
    chk("neg_min", 64'(bus.neg), 64'(1));
    write_ch(1'b1, 32'd99999999);
    wait_idle(n);
    chk("dig_max", 64'(bus.digitos), 64'(32'h99999999));
    chk("ovf_max", 64'(bus.ovf), 64'(0));
    chk("neg_max", 64'(bus.neg), 64'(0));

    // pending restart: 7 then 8 three cycles apart
    bus.disp_sel = 1'b0;
    step(1);
    wait_idle(n);
    chk("dig_back", 64'(bus.digitos), 64'(32'h00001234));
    write_ch(1'b0, 32'd7);
    step(2);
    write_ch(1'b0, 32'd8);
    wait_idle(n);
    chk("busy_pend", 64'(n), 64'(63));
    chk("dig_pend", 64'(bus.digitos), 64'(32'h00000008));
    write_ch(1'b1, 32'd77);
    chk("no_conv", 64'(bus.out_busy), 64'(0));
    step(2);
    chk("no_conv2", 64'(bus.out_busy), 64'(0));
    bus.disp_sel = 1'b1;
    step(1);
    wait_idle(n);
    chk("dig_77", 64'(bus.digitos), 64'(32'h00000077));

    // clean press with negative switch value
    bus.in_req  = 1'b1;
    bus.entrada = 18'h3FFFF;
    step(2);
    press_and_expect(32'hFFFF_FFFF, "press1");

    // bouncing key never produces an ack
    bus.in_req = 1'b1;
    step(2);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      bus.enter = ~bus.enter;
      repeat (2) begin
        step(1);
        chk("bounce_stall", 64'(bus.stall), 64'(1));
        if (bus.in_ack) acks++;
      end
    end
    chk("bounce_acks", 64'(acks), 64'(0));
    bus.in_req = 1'b0;
    bus.enter  = 1'b0;
    step(6);

    // press while idle is discarded; a fresh press is required
    bus.entrada = 18'h0ABCD;
    bus.enter   = 1'b1;
    step(12);
    bus.in_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.in_ack) acks++;
    end
    chk("idle_press_acks", 64'(acks), 64'(0));
    bus.enter = 1'b0;
    step(8);
    press_and_expect(32'h0000_ABCD, "press2");

    // reset mid-conversion with a pending trigger
    write_ch(1'b1, 32'd12345);
    step(5);
    write_ch(1'b1, 32'd54321);
    step(4);
    chk("pre_rst_busy", 64'(bus.out_busy), 64'(1));
    reset = 1'b1;
    bus.disp_sel = 1'b0;
    step(1);
    reset = 1'b0;
    chk("mid_rst_busy", 64'(bus.out_busy), 64'(0));
    chk("mid_rst_dig",  64'(bus.digitos),  64'(0));
    chk("mid_rst_neg",  64'(bus.neg),      64'(0));
    chk("mid_rst_ovf",  64'(bus.ovf),      64'(0));
    chk("mid_rst_ack",  64'(bus.in_ack),   64'(0));
    step(3);
    chk("post_rst_busy", 64'(bus.out_busy), 64'(0));
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
